// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC sequencing, IF/ID register and a one-entry skid buffer for stalls.
// Optional build macro IFU_PERF_CNT_EN adds the fetch_count performance counter output.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [63:0] if_id_out,
  output logic        if_id_valid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    ST_DRAIN = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & WORD_MASK;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] pc_plus4_s;
  logic [63:0] if_id_r;
  logic [63:0] if_id_s;
  logic        valid_r;
  logic        valid_s;
  logic [63:0] skid_r;
  logic [63:0] skid_s;
  logic        skid_valid_r;
  logic        skid_valid_s;

  // PC increment wraps naturally at 32 bits
  assign pc_plus4_s = pc_r + 32'd4;

  // Next-state, next-PC and IF/ID/skid update; redirect overrides everything else
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    if_id_s      = if_id_r;
    valid_s      = valid_r;
    skid_s       = skid_r;
    skid_valid_s = skid_valid_r;
    if (redirect) begin
      pc_s         = redirect_pc & WORD_MASK;
      valid_s      = 1'b0;
      skid_valid_s = 1'b0;
      state_s      = ST_FETCH;
    end else begin
      case (state_r)
        ST_DRAIN: begin
          state_s = ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            pc_s = pc_plus4_s;
            if (stall) begin
              skid_s       = {pc_plus4_s, imem_data};
              skid_valid_s = 1'b1;
              state_s      = ST_HOLD;
            end else begin
              if_id_s = {pc_plus4_s, imem_data};
              valid_s = 1'b1;
            end
          end else begin
            // Memory not ready: address held; a free-running ID stage sees a bubble
            if (stall) begin
              valid_s = valid_r;
            end else begin
              valid_s = 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (stall) begin
            state_s = ST_HOLD;
          end else begin
            if_id_s      = skid_r;
            valid_s      = skid_valid_r;
            skid_valid_s = 1'b0;
            state_s      = ST_FETCH;
          end
        end
        default: begin
          state_s      = ST_FETCH;
          valid_s      = 1'b0;
          skid_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State, PC, IF/ID and skid registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_DRAIN;
      pc_r         <= RESET_PC_ALIGNED;
      if_id_r      <= 64'h0;
      valid_r      <= 1'b0;
      skid_r       <= 64'h0;
      skid_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      if_id_r      <= if_id_s;
      valid_r      <= valid_s;
      skid_r       <= skid_s;
      skid_valid_r <= skid_valid_s;
    end
  end

  assign imem_req    = (state_r == ST_FETCH);
  assign imem_addr   = pc_r;
  assign if_id_out   = if_id_r;
  assign if_id_valid = valid_r;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_r;

  // Count each new instruction delivered into IF/ID (direct fetch or skid drain)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_r <= 32'h0;
    end else if (!redirect && !stall &&
                 (((state_r == ST_FETCH) && imem_ready) || (state_r == ST_HOLD))) begin
      fetch_count_r <= fetch_count_r + 32'd1;
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end

  assign fetch_count = fetch_count_r;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: stimulus pushes expected IF/ID words, a monitor pops them as they are delivered.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ready, stall, redirect, if_id_valid;
  logic [31:0] imem_addr, imem_data, redirect_pc;
  logic [63:0] if_id_out;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_data;
  logic [63:0] w_out;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count, w_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  // Memory model: word at address a is ((a/4)+1)*0x11
  function automatic logic [31:0] word_at(input logic [31:0] a);
    word_at = ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  assign imem_data = word_at(imem_addr);
  assign w_data    = word_at(w_addr);

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_out(if_id_out), .if_id_valid(if_id_valid)
`ifdef IFU_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_data(w_data), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(32'h0),
    .if_id_out(w_out), .if_id_valid(w_valid)
`ifdef IFU_PERF_CNT_EN
    , .fetch_count(w_count)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a new IF/ID word is presented when valid follows an edge taken without stall
  initial begin
    logic s;
    forever begin
      @(posedge clk);
      s = stall;
      @(negedge clk);
      if (if_id_valid && !s) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_delivery", if_id_out, 64'h0);
        end else begin
          chk("if_id_out", if_id_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    imem_ready  = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) step();
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_addr", {32'h0, imem_addr}, 64'h0);
    chk("rst_out", if_id_out, 64'h0);
    chk("rst_valid", {63'h0, if_id_valid}, 64'h0);
    chk("rst_w_addr", {32'h0, w_addr}, 64'h0000_0000_FFFF_FFFC);
    reset = 1'b1;
    #1;
    chk("drain_req", {63'h0, imem_req}, 64'h0);
    step(); // E1: DRAIN -> FETCH
    chk("first_req", {63'h0, imem_req}, 64'h1);
    chk("first_addr", {32'h0, imem_addr}, 64'h0);
    chk("w_first_addr", {32'h0, w_addr}, 64'h0000_0000_FFFF_FFFC);
    exp_q.push_back({32'd4, 32'h11});
    step(); // E2
    chk("w_wrap_out", w_out, {32'h0000_0000, 32'h4000_0000});
    chk("w_wrap_valid", {63'h0, w_valid}, 64'h1);
    chk("w_wrap_addr", {32'h0, w_addr}, 64'h0);
    exp_q.push_back({32'd8, 32'h22});
    step(); // E3
    exp_q.push_back({32'd12, 32'h33});
    step(); // E4
    redirect    = 1'b1;
    redirect_pc = 32'd4;
    step(); // E5
    chk("redir_valid", {63'h0, if_id_valid}, 64'h0);
    chk("redir_addr", {32'h0, imem_addr}, 64'd4);
    redirect = 1'b0;
    exp_q.push_back({32'd8, 32'h22});
    step(); // E6
    stall = 1'b1;
    exp_q.push_back({32'd12, 32'h33});
    for (int i = 0; i < 3; i++) begin
      step(); // E7..E9: holding
      chk("hold_req", {63'h0, imem_req}, 64'h0);
      chk("hold_out", if_id_out, {32'd8, 32'h22});
      chk("hold_valid", {63'h0, if_id_valid}, 64'h1);
      chk("hold_addr", {32'h0, imem_addr}, 64'd12);
    end
    stall = 1'b0;
    step(); // E10: skid drained
    chk("resume_req", {63'h0, imem_req}, 64'h1);
    chk("resume_addr", {32'h0, imem_addr}, 64'd12);
    exp_q.push_back({32'd16, 32'h44});
    step(); // E11
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(); // E12, E13: bubbles
      chk("bubble_valid", {63'h0, if_id_valid}, 64'h0);
      chk("bubble_addr", {32'h0, imem_addr}, 64'd16);
    end
    imem_ready = 1'b1;
    exp_q.push_back({32'd20, 32'h55});
    step(); // E14
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    stall       = 1'b1;
    step(); // E15
    chk("redir2_valid", {63'h0, if_id_valid}, 64'h0);
    chk("redir2_addr", {32'h0, imem_addr}, 64'h100);
    chk("redir2_req", {63'h0, imem_req}, 64'h1);
    chk("redir2_retain", if_id_out, {32'd20, 32'h55});
    redirect = 1'b0;
    stall    = 1'b0;
    exp_q.push_back({32'h104, 32'h451});
    step(); // E16
    stall = 1'b1;
    step(); // E17: HOLD
    chk("hold2_req", {63'h0, imem_req}, 64'h0);
`ifdef IFU_PERF_CNT_EN
    chk("fetch_count", {32'h0, fetch_count}, 64'd8);
`endif
    #2;
    reset = 1'b0;
    #1;
    chk("async_req", {63'h0, imem_req}, 64'h0);
    chk("async_addr", {32'h0, imem_addr}, 64'h0);
    chk("async_out", if_id_out, 64'h0);
    chk("async_valid", {63'h0, if_id_valid}, 64'h0);
`ifdef IFU_PERF_CNT_EN
    chk("count_rst", {32'h0, fetch_count}, 64'h0);
`endif
    repeat (2) step();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32 [0:31]  word address of the current fetch (equals PC).
REQ-006 imem_ready  input  1  imem_data is valid this cycle for the request held at imem_addr.
REQ-007 imem_data  input  32 [0:31]  fetched instruction word.
REQ-008 stall  input  1  hazard unit hold request; IF/ID contents shall not change while 1.
REQ-009 redirect  input  1  taken branch/jump/RegToPC from a later stage.
REQ-010 redirect_pc  input  32 [0:31]  new fetch target, valid when redirect=1.
REQ-011 if_id_out  output  64 [0:63]  IF/ID payload {nextPC[0:31], instruction[32:63]}.
REQ-012 if_id_valid  output  1  if_id_out holds a live instruction; 0 = bubble.

Function
REQ-013 The unit SHALL implement three states: FETCH (imem_req=1), HOLD (one captured instruction buffered, imem_req=0), DRAIN (one cycle after reset release, imem_req=0, moves to FETCH).
REQ-014 In FETCH with imem_ready=1 and stall=0, the next edge SHALL load if_id_out={PC+4, imem_data}, set if_id_valid=1, and advance PC to PC+4 (one-cycle fetch-to-IF/ID latency).
REQ-015 In FETCH with imem_ready=1 and stall=1, the unit SHALL capture {PC+4, imem_data} in a one-entry skid buffer, advance PC, hold if_id_out/if_id_valid, and enter HOLD.
REQ-016 In FETCH with imem_ready=0, PC and imem_addr SHALL hold; if stall=0, if_id_valid SHALL go to 0 at the next edge (bubble); if stall=1, IF/ID holds.
REQ-017 In HOLD with stall=0, the next edge SHALL move the skid buffer into if_id_out, set if_id_valid=1, and return to FETCH; with stall=1 it SHALL remain in HOLD.
REQ-018 redirect=1 SHALL have priority over stall, imem_ready and state: next edge PC=redirect_pc with bits [30:31] forced to 0, if_id_valid=0, skid buffer discarded, state=FETCH; any imem_data returned that cycle SHALL be discarded.
REQ-019 PC arithmetic SHALL be 32-bit modulo: PC 32'hFFFF_FFFC advances to 32'h0000_0000 with nextPC=32'h0000_0000.
REQ-020 imem_addr SHALL equal PC combinationally; imem_addr SHALL NOT change while imem_req=1 and imem_ready=0, except on redirect.
REQ-021 if_id_out SHALL retain its last value when if_id_valid=0; consumers qualify it with if_id_valid.

Reset
REQ-022 While reset=0: PC=RESET_PC (bits [30:31] forced 0), state=DRAIN, imem_req=0, if_id_out=64'h0, if_id_valid=0, skid buffer empty.
REQ-023 Reset assertion mid-fetch or in HOLD SHALL take effect immediately, without waiting for clk; a pending imem_ready SHALL be ignored.
REQ-024 First imem_req=1 SHALL occur in the second clk cycle after reset deasserts.

Configuration
REQ-025 With IFU_PERF_CNT_EN defined, the unit SHALL add output fetch_count (32 bits): reset to 0, incremented by 1 on every edge that sets if_id_valid=1 with a new instruction (REQ-014, REQ-017), wrapping 32'hFFFF_FFFF to 0, not incremented on redirect, bubbles or held cycles.
REQ-026 Without IFU_PERF_CNT_EN, the fetch_count port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Reset release, RESET_PC=0, imem_ready=1 always, data 0x11,0x22,0x33 -> if_id_out {4,0x11},{8,0x22},{12,0x33} on consecutive cycles, valid=1.
REQ-028 stall=1 for 3 cycles while imem_ready=1 at PC=8 -> IF/ID frozen, state HOLD, imem_req=0; after stall drops, if_id_out={12,word@8}, then fetch resumes at 12.
REQ-029 imem_ready=0 for 2 cycles at PC=16, stall=0 -> imem_addr stays 16, two bubbles (valid=0), then {20,word@16}.
REQ-030 redirect=1, redirect_pc=0x0000_0103 same cycle as imem_ready=1 and stall=1 -> returned word dropped, valid=0, next imem_addr=0x0000_0100.
REQ-031 RESET_PC=32'hFFFF_FFFC, imem_ready=1 -> if_id_out={0x0000_0000, word}, next imem_addr=0; reset pulsed low mid-HOLD -> all outputs zero at once; with IFU_PERF_CNT_EN, fetch_count=0 after reset and increments once per delivered instruction only.
